// File: rtl/segmented_data_memory.sv
// rtl/segmented_data_memory.sv - address-decoded multi-segment data RAM with fixed-latency request/response handshake
// Writes commit on the accepting edge; read data is captured on that edge and presented after WAIT_STATES+1 cycles.
module segmented_data_memory #(
    parameter int                    NUM_SEGS       = 2,
    parameter logic [NUM_SEGS*16-1:0] SEG_BASE      = {16'h7fff, 16'h1000},
    parameter int                    SEG_DEPTH_LOG2 = 10,
    parameter int                    WAIT_STATES    = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int SEG_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam int IDX_W = SEG_W + SEG_DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [2**IDX_W];

    logic             hit;
    logic [SEG_W-1:0] seg_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             fault;
    logic             accept;
    logic             wr_en;
    logic [3:0]       be;
    logic [31:0]      wr_lanes;
    logic [31:0]      rd_word;
    logic [31:0]      load_data;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic             unused_addr;

    // Only the segment word offset and match field matter; the rest of the offset wraps.
    assign unused_addr = ^req_addr;

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        seg_idx = '0;
        for (int i = NUM_SEGS - 1; i >= 0; i--) begin
            if (req_addr[31:16] == SEG_BASE[i*16 +: 16]) begin
                hit     = 1'b1;
                seg_idx = SEG_W'(i);
            end
        end
    end

    assign mem_idx = {seg_idx, req_addr[SEG_DEPTH_LOG2+1:2]};
    assign fault   = !hit
                   || (req_size == 2'b10)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
    assign accept  = req_valid && req_ready;
    assign wr_en   = accept && req_we && !fault;

    always_comb begin
        be       = 4'b0000;
        wr_lanes = req_wdata;
        case (req_size)
            2'b00: begin
                be       = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be       = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{req_wdata[15:0]}};
            end
            2'b11: begin
                be       = 4'b1111;
                wr_lanes = req_wdata;
            end
            default: begin
                be       = 4'b0000;
                wr_lanes = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    assign rd_word  = mem_q[mem_idx];
    assign byte_sel = rd_word[8*req_addr[1:0] +: 8];
    assign half_sel = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (req_size)
            2'b00:   load_data = {{24{req_sign & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{req_sign & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = (req_we || fault) ? 32'd0 : load_data;
                    err_d   = fault;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && reset;
        resp_valid = (state_q == RESP);
        resp_rdata = resp_valid ? rdata_q : 32'd0;
        resp_err   = resp_valid && err_q;
    end

endmodule

// File: tb/tb_segmented_data_memory.sv
// tb/tb_segmented_data_memory.sv - self-checking bench for segmented_data_memory
// Instance 0 runs with no wait states, instance 1 with three; both share clock and reset.
module tb_segmented_data_memory;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [1:0]  req_valid, req_ready, req_we, req_sign, resp_valid, resp_err;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] resp_rdata [2];
    logic [1:0]  req_size [2];

    int total = 0;
    int bad   = 0;

    bit   [7:0]  mdl [int];
    logic [15:0] bases [2] = '{16'h1000, 16'h7fff};
    int          ws_of [2] = '{0, 3};

    segmented_data_memory #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .req_sign(req_sign[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0])
    );

    segmented_data_memory #(.WAIT_STATES(3)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .req_sign(req_sign[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed model: each instance owns its own image, each segment a 4KB window.
    function automatic void model_access(input int d, input bit we, input logic [31:0] a,
                                         input logic [31:0] wd, input logic [1:0] sz,
                                         input bit sg, output logic [31:0] rd, output bit er);
        int          seg;
        int          nbytes;
        int          loc;
        logic [31:0] val;
        seg = -1;
        for (int i = 0; i < 2; i++)
            if (seg < 0 && a[31:16] == bases[i]) seg = i;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        er  = (seg < 0) || (sz == 2'b10) || ((int'(a[1:0]) % nbytes) != 0);
        rd  = 32'd0;
        val = 32'd0;
        if (!er) begin
            loc = d * 65536 + seg * 4096 + int'(a[11:0]);
            if (we) begin
                for (int k = 0; k < nbytes; k++) mdl[loc + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < nbytes; k++)
                    if (mdl.exists(loc + k)) val = val | (32'(mdl[loc + k]) << (8 * k));
                if (sg && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
                rd = val;
            end
        end
    endfunction

    task automatic do_req(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input bit sg,
                          output logic [31:0] rd, output logic er, output int lat);
        int w;
        @(negedge clock);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
        req_wdata[d] = wd;   req_size[d] = sz; req_sign[d] = sg;
        w = 0;
        while (req_ready[d] !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("accept_ready", 32'(req_ready[d]), 32'd1);
        @(posedge clock);
        #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        lat = 1;
        @(negedge clock);
        while (resp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        @(negedge clock);
        chk("resp_one_cycle", 32'(resp_valid[d]), 32'd0);
        chk("rdata_idle_zero", resp_rdata[d], 32'd0);
    endtask

    task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit sg, input string tag,
                       output logic [31:0] rd);
        logic [31:0] exp_rd;
        bit          exp_er;
        logic        er;
        int          lat;
        model_access(d, we, a, wd, sz, sg, exp_rd, exp_er);
        do_req(d, we, a, wd, sz, sg, rd, er, lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
        chk({tag, "_lat"}, 32'(lat), 32'(ws_of[d] + 1));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] exp_rd;
        bit          exp_er;
        int          acc [$];
        int          rsp [$];
        int          ready_hi;

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_size[d] = 2'b11; req_sign[d] = 1'b0;
        end
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);

        txn(0, 1, 32'h1000_0008, 32'hDEAD_BEEF, 2'b11, 0, "w_word", rd);
        txn(0, 0, 32'h1000_0008, 32'h0, 2'b11, 0, "r_word", rd);
        chk("r_word_const", rd, 32'hDEAD_BEEF);

        txn(0, 1, 32'h7fff_0003, 32'h0000_0080, 2'b00, 0, "w_byte", rd);
        txn(0, 0, 32'h7fff_0003, 32'h0, 2'b00, 1, "r_byte_s", rd);
        chk("r_byte_s_const", rd, 32'hFFFF_FF80);
        txn(0, 0, 32'h7fff_0003, 32'h0, 2'b00, 0, "r_byte_u", rd);
        chk("r_byte_u_const", rd, 32'h0000_0080);
        txn(0, 0, 32'h7fff_0000, 32'h0, 2'b11, 1, "r_byte_word", rd);
        chk("r_byte_word_const", rd, 32'h8000_0000);

        txn(0, 0, 32'h1000_0001, 32'h0, 2'b01, 0, "f_half", rd);
        txn(0, 0, 32'h1000_0002, 32'h0, 2'b11, 0, "f_word", rd);
        txn(0, 0, 32'h1000_0008, 32'h0, 2'b10, 0, "f_size", rd);
        txn(0, 0, 32'h2000_0000, 32'h0, 2'b11, 0, "f_miss", rd);
        txn(0, 1, 32'h1000_000A, 32'h5555_5555, 2'b11, 0, "f_wr", rd);
        txn(0, 1, 32'h2000_0008, 32'h5555_5555, 2'b11, 0, "f_wr_miss", rd);
        txn(0, 0, 32'h1000_0008, 32'h0, 2'b11, 0, "f_unchanged", rd);
        chk("f_unchanged_const", rd, 32'hDEAD_BEEF);

        txn(0, 1, 32'h1000_1008, 32'h1234_5678, 2'b11, 0, "w_wrap", rd);
        txn(0, 0, 32'h1000_0008, 32'h0, 2'b11, 0, "r_wrap", rd);
        chk("r_wrap_const", rd, 32'h1234_5678);

        txn(1, 1, 32'h1000_0000, 32'hA5C3_7E19, 2'b11, 0, "ws3_w", rd);
        txn(1, 0, 32'h1000_0000, 32'h0, 2'b11, 0, "ws3_r", rd);

        // Hold a read request continuously on the three-wait-state instance.
        model_access(1, 0, 32'h1000_0000, 32'h0, 2'b11, 0, exp_rd, exp_er);
        @(negedge clock);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h1000_0000; req_size[1] = 2'b11;
        ready_hi = 0;
        for (int c = 0; c < 16; c++) begin
            if (req_ready[1] === 1'b1) begin acc.push_back(c); ready_hi++; end
            if (resp_valid[1] === 1'b1) begin
                rsp.push_back(c);
                chk("b2b_rdata", resp_rdata[1], exp_rd);
            end
            @(negedge clock);
        end
        req_valid[1] = 1'b0;
        repeat (8) @(negedge clock);
        chk("b2b_accepts", 32'(acc.size()), 32'd4);
        chk("b2b_ready_hi", 32'(ready_hi), 32'd4);
        chk("b2b_resps", 32'(rsp.size()), 32'd3);
        if (acc.size() >= 2) chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd5);
        if (acc.size() >= 1 && rsp.size() >= 1) chk("b2b_latency", 32'(rsp[0] - acc[0]), 32'd4);

        // Reset in the wait phase after a write: response dropped, write kept.
        model_access(1, 1, 32'h1000_0010, 32'hCAFE_F00D, 2'b11, 0, exp_rd, exp_er);
        @(negedge clock);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h1000_0010;
        req_wdata[1] = 32'hCAFE_F00D; req_size[1] = 2'b11; req_sign[1] = 1'b0;
        chk("rstw_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clock);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("rstw_no_resp", 32'(resp_valid[1]), 32'd0);
            chk("rstw_no_ready", 32'(req_ready[1]), 32'd0);
        end
        reset = 1'b1;
        txn(1, 0, 32'h1000_0010, 32'h0, 2'b11, 0, "rstw_read", rd);
        chk("rstw_read_const", rd, 32'hCAFE_F00D);

        for (int n = 0; n < 90; n++) begin
            int          d;
            int          sel;
            logic [15:0] off;
            d   = (n < 70) ? 0 : 1;
            sel = $urandom_range(0, 5);
            off = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) off = off | 16'h1000;
            if ($urandom_range(0, 7) == 0) off = off | 16'h8000;
            case (sel)
                0, 1:    a = {16'h1000, off};
                2, 3:    a = {16'h7fff, off};
                4:       a = {16'h1001, off};
                default: a = {16'($urandom), off};
            endcase
            txn(d, 1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), "rand", rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
